// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the pwm fade sequencer: state encoding and default word widths.
// The bench imports the same package so both sides agree on the debug state values.
package pwm_fade_ctrl_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } fade_state_e;

endpackage

// File: rtl/pwm_fade_ctrl_duty_step.sv
// One duty step toward a target: unsigned distance, step saturation onto the target.
// Purely combinational; the sequencer decides when the result is registered.
module pwm_duty_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_target,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_next,
  output logic             o_reached
);

  logic             w_up;
  logic [WIDTH-1:0] w_dist;

  // Distance is taken in the direction that cannot underflow, so the step never wraps.
  always_comb begin
    w_up      = (i_target > i_cur);
    w_dist    = w_up ? (i_target - i_cur) : (i_cur - i_target);
    o_reached = (i_step == '0) || (w_dist <= i_step);
    if (o_reached) begin
      o_next = i_target;
    end else if (w_up) begin
      o_next = i_cur + i_step;
    end else begin
      o_next = i_cur - i_step;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for one pwm: accepts a command, ramps high_time toward the target once
// per pwm period, holds for a number of periods, then reports done (or aborted).
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_period,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [WIDTH-1:0]  cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  input  logic              last_cycle,
  output logic [WIDTH-1:0]  wave_length,
  output logic [WIDTH-1:0]  high_time,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output fade_state_e       dbg_state
);

  // Command handshake: a command is taken on a rising clk edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only while idle, so offers during a
  // fade are simply not taken. cmd_* need only be stable in that accepting cycle.

  fade_state_e       r_state;
  logic [WIDTH-1:0]  r_period;
  logic [WIDTH-1:0]  r_target;
  logic [WIDTH-1:0]  r_step;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_abort_pend;

  logic [WIDTH-1:0]  w_next;
  logic              w_reached;
  logic              w_abort_req;

  assign w_abort_req = r_abort_pend | abort;
  assign dbg_state   = r_state;

  pwm_duty_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_cur     (high_time),
    .i_target  (r_target),
    .i_step    (r_step),
    .o_next    (w_next),
    .o_reached (w_reached)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_period     <= '0;
      r_target     <= '0;
      r_step       <= '0;
      r_hold       <= '0;
      r_hold_cnt   <= '0;
      r_abort_pend <= 1'b0;
      wave_length  <= '0;
      high_time    <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_abort_pend <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            r_period  <= cmd_period;
            r_target  <= cmd_target;
            r_step    <= cmd_step;
            r_hold    <= cmd_hold;
            r_state   <= ST_RAMP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_RAMP: begin
          if (abort) r_abort_pend <= 1'b1;
          if (last_cycle) begin
            if (w_abort_req) begin
              high_time    <= '0;
              aborted      <= 1'b1;
              busy         <= 1'b0;
              r_abort_pend <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              wave_length <= r_period;
              high_time   <= w_next;
              if (w_reached) begin
                r_hold_cnt <= r_hold;
                r_state    <= ST_HOLD;
              end
            end
          end
        end

        ST_HOLD: begin
          if (abort) r_abort_pend <= 1'b1;
          // A pending abort outranks completion and still waits for a period edge.
          if (w_abort_req) begin
            if (last_cycle) begin
              high_time    <= '0;
              aborted      <= 1'b1;
              busy         <= 1'b0;
              r_abort_pend <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end else if (r_hold_cnt == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (last_cycle) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl with a simple pwm counter closing the last_cycle loop.
module tb_pwm_fade_ctrl;
  import pwm_fade_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_period = '0;
  logic [W-1:0]  cmd_target = '0;
  logic [W-1:0]  cmd_step = '0;
  logic [HW-1:0] cmd_hold = '0;
  logic          abort = 1'b0;
  logic          last_cycle;
  logic [W-1:0]  wave_length;
  logic [W-1:0]  high_time;
  logic          busy;
  logic          done;
  logic          aborted;
  fade_state_e   dbg_state;

  // ---------------- clock / pwm model ----------------
  always #5 clk = ~clk;

  logic [W-1:0] pwm_cnt = '0;
  assign last_cycle = (pwm_cnt >= wave_length);
  always @(posedge clk) pwm_cnt <= last_cycle ? '0 : pwm_cnt + 1'b1;

  pwm_fade_ctrl #(.WIDTH(W), .HOLD_W(HW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_period  (cmd_period),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_hold    (cmd_hold),
    .abort       (abort),
    .last_cycle  (last_cycle),
    .wave_length (wave_length),
    .high_time   (high_time),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // item = {kind[1:0] (0 word, 1 done, 2 aborted), boundary index[7:0], wave_length, high_time}
  logic [25:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic pop_cmp(string name, logic [25:0] act);
    logic [25:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event actual=%0h expected=none at %0t", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  // ---------------- monitor ----------------
  bit          chk_en = 1'b0;
  int          bcnt = 0;
  int          plen = 0;
  bit          seen_first = 1'b0;
  logic        lc_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic [W-1:0] prev_wl = '0;
  logic [W-1:0] prev_ht = '0;
  logic [W-1:0] start_wl = '0;

  always @(negedge clk) begin
    if (!chk_en) begin
      plen       = 0;
      seen_first = 1'b0;
      bcnt       = 0;
    end else begin
      if (lc_prev) bcnt++;
      if (busy && !busy_prev) bcnt = 0;
      plen++;
      if (lc_prev) begin
        if (seen_first) check("period_len", 32'(plen), 32'(start_wl) + 32'd1);
        seen_first = 1'b1;
        plen       = 0;
        start_wl   = wave_length;
      end
      check("busy_vs_state", 32'(busy), 32'(dbg_state != ST_IDLE));
      if (wave_length !== prev_wl || high_time !== prev_ht) begin
        check("word_at_boundary", 32'(lc_prev), 32'd1);
        pop_cmp("word", {2'd0, 8'(bcnt), wave_length, high_time});
      end
      if (done)    pop_cmp("done",    {2'd1, 8'(bcnt), wave_length, high_time});
      if (aborted) pop_cmp("aborted", {2'd2, 8'(bcnt), wave_length, high_time});
    end
    lc_prev   = last_cycle;
    busy_prev = busy;
    prev_wl   = wave_length;
    prev_ht   = high_time;
  end

  // ---------------- reference model / driver ----------------
  int m_wl = 0;
  int m_ht = 0;

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_wave_length"}, 32'(wave_length), 32'd0);
    check({tag, "_high_time"},   32'(high_time),   32'd0);
    check({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_aborted"},     32'(aborted),     32'd0);
  endtask

  // stop_kind: 0 run to done, 1 abort after boundary stop_k, 2 reset after boundary stop_k.
  // stop_k < 0 picks a random boundary within the ramp+hold span.
  task automatic run_cmd(input int period, input int target, input int step, input int hold,
                         input int stop_kind, input int stop_k_in, input bit garble);
    int  d, n, lim, v, pw, ph, stop_k;
    bit  fin, sent;
    d = (target >= m_ht) ? target - m_ht : m_ht - target;
    n = (step == 0 || d <= step) ? 1 : (d + step - 1) / step;
    stop_k = (stop_k_in < 0) ? int'($urandom_range(1, n + hold)) : stop_k_in;
    lim = (stop_kind != 0 && stop_k < n) ? stop_k : n;
    pw = m_wl;
    ph = m_ht;
    for (int i = 1; i <= lim; i++) begin
      if (i == n)          v = target;
      else if (target > m_ht) v = m_ht + i * step;
      else                 v = m_ht - i * step;
      if (period != pw || v != ph) exp_q.push_back({2'd0, 8'(i), 8'(period), 8'(v)});
      pw = period;
      ph = v;
    end
    if (stop_kind == 0) begin
      exp_q.push_back({2'd1, 8'(n + hold), 8'(pw), 8'(ph)});
    end else if (stop_kind == 1) begin
      if (ph != 0) exp_q.push_back({2'd0, 8'(stop_k + 1), 8'(pw), 8'd0});
      exp_q.push_back({2'd2, 8'(stop_k + 1), 8'(pw), 8'd0});
      ph = 0;
    end
    m_wl = pw;
    m_ht = ph;

    wait_neg();
    cmd_period = W'(period);
    cmd_target = W'(target);
    cmd_step   = W'(step);
    cmd_hold   = HW'(hold);
    cmd_valid  = 1'b1;
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    wait_neg();
    if (!garble) cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_low_when_busy", 32'(cmd_ready), 32'd0);

    fin  = 1'b0;
    sent = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (garble) begin
        cmd_period = W'($urandom_range(0, 255));
        cmd_target = W'($urandom_range(0, 255));
        cmd_step   = W'($urandom_range(0, 255));
        cmd_hold   = HW'($urandom_range(0, 255));
      end
      if (stop_kind != 0 && !sent && bcnt == stop_k) begin
        sent = 1'b1;
        if (stop_kind == 1) begin
          abort = 1'b1;
          wait_neg();
          abort = 1'b0;
        end else begin
          chk_en = 1'b0;
          rst = 1'b1;
          #1;
          check_reset_outputs("midhold_rst");
          check("queue_drained_before_rst", 32'(exp_q.size()), 32'd0);
          exp_q.delete();
          cmd_valid = 1'b0;
          wait_neg();
          wait_neg();
          rst = 1'b0;
          m_wl = 0;
          m_ht = 0;
          wait_neg();
          chk_en = 1'b1;
          fin = 1'b1;
        end
      end
      if (!fin) begin
        if (done || aborted) begin
          check("ready_low_at_finish", 32'(cmd_ready), 32'd0);
          cmd_valid = 1'b0;
          wait_neg();
          check("ready_after_finish", 32'(cmd_ready), 32'd1);
          check("idle_after_finish", 32'(busy), 32'd0);
          fin = 1'b1;
        end else begin
          wait_neg();
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout actual=busy expected=finished at %0t", $time);
      exp_q.delete();
      cmd_valid = 1'b0;
      abort = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) wait_neg();
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_neg();
    chk_en = 1'b1;
    repeat (3) wait_neg();

    run_cmd(9, 8, 3, 2, 0, 0, 1'b0);      // ramp up 3,6,8 then hold 2
    abort = 1'b1;                          // abort while idle must be ignored
    wait_neg();
    abort = 1'b0;
    wait_neg();
    run_cmd(9, 1, 4, 0, 0, 0, 1'b0);      // ramp down 4,1
    run_cmd(9, 5, 0, 0, 0, 0, 1'b0);      // jump in one period
    run_cmd(9, 40, 5, 1, 1, 2, 1'b0);     // abort mid-ramp
    run_cmd(9, 6, 2, 1, 1, 4, 1'b0);      // abort on the done clk
    run_cmd(7, 3, 1, 1, 0, 0, 1'b1);      // cmd_valid held while busy
    run_cmd(9, 4, 0, 5, 2, 3, 1'b0);      // reset mid-hold
    run_cmd(9, 4, 1, 0, 0, 0, 1'b0);
    run_cmd(3, 2, 1, 0, 0, 0, 1'b0);      // period shrink 9 -> 3

    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0)
        run_cmd(int'($urandom_range(2, 12)), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1, -1, 1'b0);
      else
        run_cmd(int'($urandom_range(2, 12)), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 0, 0,
                1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 4))) wait_neg();
    end

    repeat (20) wait_neg();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
